// File: rtl/equal_mon_pkg.sv
// Types and widths shared between the equality counter and its rate monitor.
package equal_mon_pkg;
  localparam int unsigned CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;
endpackage

// File: rtl/equal_rate_monitor_if.sv
// Valid/ready channel carrying one window's match count to the consumer.
interface equal_rate_monitor_if;
  equal_mon_pkg::cnt_t win_delta;
  logic                win_valid;
  logic                win_ready;

  modport master (output win_delta, output win_valid, input win_ready);
  modport slave  (input win_delta, input win_valid, output win_ready);
endinterface

// File: rtl/equal_rate_monitor_window_timer.sv
// Enable-gated window counter; tc pulses on the enabled cycle that completes a window.
module window_timer
  import equal_mon_pkg::*;
#(
  parameter int unsigned WINDOW_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam cnt_t LAST = cnt_t'(WINDOW_LEN - 1);

  cnt_t count;

  assign tc = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count <= '0;
    else if (clr)     count <= '0;
    else if (tc)      count <= '0;
    else if (en)      count <= count + cnt_t'(1);
  end

endmodule

// File: rtl/equal_rate_monitor.sv
// Per-window match counter over a valid/ready channel, with hysteresis alarm and sticky overrun.
module equal_rate_monitor
  import equal_mon_pkg::*;
#(
  parameter int unsigned WINDOW_LEN = 16,
  parameter int unsigned HI_THRESH  = 8,
  parameter int unsigned LO_THRESH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  cnt_t                         equal_cnt,
  input  logic                         enable,
  input  logic                         clear,
  equal_rate_monitor_if.master         win,
  output logic                         alarm,
  output logic                         overrun
);

  localparam cnt_t HI = cnt_t'(HI_THRESH);
  localparam cnt_t LO = cnt_t'(LO_THRESH);

  state_t state;
  cnt_t   base;
  cnt_t   delta;
  logic   tc;
  logic   boundary;

  // The PAUSE->RUN edge also counts, so each disabled cycle delays the window by exactly one.
  window_timer #(.WINDOW_LEN(WINDOW_LEN)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (clear || (state == IDLE)),
    .en  (enable && (state != IDLE)),
    .tc  (tc)
  );

  assign delta    = equal_cnt - base;
  assign boundary = tc && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      base          <= '0;
      win.win_delta <= '0;
      win.win_valid <= 1'b0;
      alarm         <= 1'b0;
      overrun       <= 1'b0;
    end else if (clear) begin
      state         <= IDLE;
      win.win_valid <= 1'b0;
      alarm         <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          base  <= equal_cnt;
          state <= RUN;
        end
        RUN:     if (!enable) state <= PAUSE;
        PAUSE:   if (enable)  state <= RUN;
        default: state <= IDLE;
      endcase

      if (boundary) begin
        win.win_delta <= delta;
        win.win_valid <= 1'b1;
        base          <= equal_cnt;
        if (win.win_valid && !win.win_ready) overrun <= 1'b1;
        if (delta >= HI)      alarm <= 1'b1;
        else if (delta <= LO) alarm <= 1'b0;
      end else if (win.win_valid && win.win_ready) begin
        win.win_valid <= 1'b0;
      end
    end
  end

endmodule
